decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the 5-stage pipeline CPU. Takes the IF/ID instruction and drives the register file read ports. Merges in the same-cycle write-back value, detects load-use hazards, and registers the operands and control into the ID/EX pipeline register consumed by the execute stage. One instruction per cycle when not stalled.

## Interface
- DATA_W, 32, datapath and instruction width
- REG_A, 5, register address width
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  reset rstn, synchronous, active-low; clock clk
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  DATA_W  instruction; opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0]
- id_pc  in  DATA_W  PC of id_instr
- rf_ra_addr  out  REG_A  register-file port A address, combinational = rs
- rf_rb_addr  out  REG_A  register-file port B address, combinational = rt
- rf_ra_data, rf_rb_data  in  DATA_W  combinational register-file read data
- wb_en  in  1  write-back valid this cycle (same signal as register-file w_en)
- wb_addr  in  REG_A  write-back destination
- wb_data  in  DATA_W  write-back data
- flush  in  1  branch taken in EX; squash the instruction in ID
- ex_stall  in  1  EX cannot accept; hold ID/EX
- id_stall  out  1  combinational; IF and IF/ID must hold
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_illegal  out  1 each  registered control
- ex_ra_data, ex_rb_data, ex_imm, ex_pc  out  DATA_W  registered operands, sign-extended imm, PC
- ex_dest  out  REG_A  registered destination register
- ex_funct  out  6  registered funct field

## Operation
- Decode by opcode:
  - 000000 R-type: reg_write=1, dest=rd, uses rs and rt.
  - 001000 ADDI: reg_write, alu_src, dest=rt, uses rs.
  - 100011 LW: reg_write, mem_read, alu_src, dest=rt, uses rs.
  - 101011 SW: mem_write, alu_src, uses rs and rt, dest=0.
  - 000100 BEQ: branch, uses rs and rt, dest=0.
  - Any other opcode: all controls 0, ex_illegal=1, ex_valid=1.
- Operand select, independently per port A/B, in priority order:
  1. Address == 0: output 0. The register file does not hardwire r0.
  2. wb_en && wb_addr == addr: output wb_data. The register file write lands only at the same posedge, so this bypass is required.
  3. Otherwise: output the register-file read data.
- An R-type whose rd field is 0 gets reg_write forced to 0.
- ex_imm = {{16{imm[15]}}, imm}.
- Load-use hazard = ex_valid && ex_mem_read && ex_dest != 0 && id_valid && ((ex_dest == rs && uses_rs) || (ex_dest == rt && uses_rt)).
- id_stall = (hazard && !flush) || ex_stall.
- ID/EX update per posedge, first matching rule wins:
  1. !rstn: all ex_* outputs = 0.
  2. flush: bubble (ex_valid and all control 0, data don't-care, driven 0).
  3. ex_stall: hold all ex_* outputs.
  4. hazard: bubble.
  5. Otherwise: load the decoded instruction, with ex_valid = id_valid.
- A bubble or invalid slot always has reg_write, mem_read, mem_write and branch at 0.

## Timing
- Latency: decode result visible on ex_* one cycle after presentation on id_*.
- rf_ra_addr/rf_rb_addr and id_stall are combinational from id_instr and the current ID/EX state. There is no registered path.
- Load-use costs exactly one bubble:
  - Cycle N: hazard, id_stall=1, bubble loaded into ID/EX.
  - Cycle N+1: the LW has moved out of ID/EX, so the hazard clears and the instruction is loaded.
- Reset mid-stream: the next posedge clears ID/EX regardless of flush/ex_stall. id_stall=0 while reset is held and ex_valid=0 (unless ex_stall=1).
- A flush during ex_stall still bubbles ID/EX. EX must tolerate the loss of the held instruction, which is on the squashed path.
- Hazard detection ignores write-back: r0 is never a hazard, and a WB-stage producer is covered by the bypass.

## Test plan
- Reset:
  - Stimulus: hold rstn=0 for 2 cycles with id_valid=1, ADDI r1,r0,5.
  - Response: every ex_* output 0 and id_stall 0. After release, the next cycle gives ex_valid=1, ex_dest=1, ex_imm=5, ex_alu_src=1.
- WB bypass:
  - Stimulus: wb_en=1, wb_addr=3, wb_data=0xDEAD_BEEF; ID holds R-type rs=3, rt=4, rd=5, with regfile r3=0x11 and r4=0x22.
  - Response: ex_ra_data=0xDEADBEEF, ex_rb_data=0x22, ex_dest=5.
- r0:
  - Stimulus: wb_en=1, wb_addr=0, wb_data=7; ID holds rs=0 with regfile r0 written nonzero.
  - Response: ex_ra_data=0. Separately, an R-type with rd=0 must give ex_reg_write=0.
- Load-use:
  - Stimulus: LW r2,4(r1) followed by ADD r6,r2,r7.
  - Response: one cycle with id_stall=1 and an ID/EX bubble (ex_valid=0), then the ADD appears with ex_ra_data from the bypass or regfile. Also check that SW r2,0(r8) after LW r2 stalls via rt, while ADDI r9,r8,1 does not stall.
- Stalls and flush:
  - ex_stall=1 for 3 cycles with an instruction in ID/EX: ex_* held constant and id_stall=1.
  - flush=1 together with ex_stall=1: next cycle ex_valid=0.
  - flush during a load-use hazard: id_stall=0 and a bubble is loaded.
- Illegal:
  - Stimulus: opcode 111111.
  - Response: ex_valid=1, ex_illegal=1, and reg_write, mem_read, mem_write, branch all 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode: register read with write-back bypass, load-use
// hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_A  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_instr,
    input  logic [DATA_W-1:0] id_pc,
    output logic [REG_A-1:0]  rf_ra_addr,
    output logic [REG_A-1:0]  rf_rb_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    input  logic              wb_en,
    input  logic [REG_A-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              id_stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_alu_src,
    output logic              ex_illegal,
    output logic [DATA_W-1:0] ex_ra_data,
    output logic [DATA_W-1:0] ex_rb_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_A-1:0]  ex_dest,
    output logic [5:0]        ex_funct
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic              illegal;
        logic [DATA_W-1:0] ra_data;
        logic [DATA_W-1:0] rb_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [REG_A-1:0]  dest;
        logic [5:0]        funct;
    } id_ex_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    logic [5:0]        opcode;
    logic [REG_A-1:0]  rs;
    logic [REG_A-1:0]  rt;
    logic [REG_A-1:0]  rd;
    logic [DATA_W-1:0] ra_sel;
    logic [DATA_W-1:0] rb_sel;
    logic              uses_rs;
    logic              uses_rt;
    logic              hazard;
    id_ex_t            dec;
    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;

    assign opcode     = id_instr[31:26];
    assign rs         = id_instr[25:21];
    assign rt         = id_instr[20:16];
    assign rd         = id_instr[15:11];
    assign rf_ra_addr = rs;
    assign rf_rb_addr = rt;

    // r0 is not hardwired in the register file, and a same-cycle write
    // lands too late to be read, so both are resolved here.
    always_comb begin
        if (rs == '0)
            ra_sel = '0;
        else if (wb_en && wb_addr == rs)
            ra_sel = wb_data;
        else
            ra_sel = rf_ra_data;
        if (rt == '0)
            rb_sel = '0;
        else if (wb_en && wb_addr == rt)
            rb_sel = wb_data;
        else
            rb_sel = rf_rb_data;
    end

    always_comb begin
        dec         = '0;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        dec.valid   = id_valid;
        dec.ra_data = ra_sel;
        dec.rb_data = rb_sel;
        dec.imm     = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
        dec.pc      = id_pc;
        dec.funct   = id_instr[5:0];
        unique case (1'b1)
            opcode == OP_R: begin
                dec.reg_write = rd != '0;
                dec.dest      = rd;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            opcode == OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.dest      = rt;
                uses_rs       = 1'b1;
            end
            opcode == OP_LW: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.dest      = rt;
                uses_rs       = 1'b1;
            end
            opcode == OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            opcode == OP_BEQ: begin
                dec.branch = 1'b1;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (!id_valid) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.alu_src   = 1'b0;
            dec.illegal   = 1'b0;
        end
    end

    assign hazard = id_ex_q.valid && id_ex_q.mem_read
                  && id_ex_q.dest != '0 && id_valid
                  && ((id_ex_q.dest == rs && uses_rs)
                   || (id_ex_q.dest == rt && uses_rt));

    assign id_stall = (hazard && !flush) || ex_stall;

    always_comb begin
        id_ex_d = id_ex_q;
        if (flush)
            id_ex_d = '0;
        else if (ex_stall)
            id_ex_d = id_ex_q;
        else if (hazard)
            id_ex_d = '0;
        else
            id_ex_d = dec;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            id_ex_q <= '0;
        else
            id_ex_q <= id_ex_d;
    end

    assign ex_valid     = id_ex_q.valid;
    assign ex_reg_write = id_ex_q.reg_write;
    assign ex_mem_read  = id_ex_q.mem_read;
    assign ex_mem_write = id_ex_q.mem_write;
    assign ex_branch    = id_ex_q.branch;
    assign ex_alu_src   = id_ex_q.alu_src;
    assign ex_illegal   = id_ex_q.illegal;
    assign ex_ra_data   = id_ex_q.ra_data;
    assign ex_rb_data   = id_ex_q.rb_data;
    assign ex_imm       = id_ex_q.imm;
    assign ex_pc        = id_ex_q.pc;
    assign ex_dest      = id_ex_q.dest;
    assign ex_funct     = id_ex_q.funct;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic
// checked against a behavioural model of the ID/EX register.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  rf_ra_addr;
    logic [4:0]  rf_rb_addr;
    logic [31:0] rf_ra_data;
    logic [31:0] rf_rb_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_stall;
    logic        id_stall;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_alu_src;
    logic        ex_illegal;
    logic [31:0] ex_ra_data;
    logic [31:0] ex_rb_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_funct;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_stall(ex_stall), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
        .ex_illegal(ex_illegal),
        .ex_ra_data(ex_ra_data), .ex_rb_data(ex_rb_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_dest(ex_dest), .ex_funct(ex_funct)
    );

    logic [31:0] rf [32];
    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];

    typedef struct {
        bit        valid, rw, mr, mw, br, as, ill;
        bit [31:0] ra, rb, imm, pc;
        int        dest;
        int        funct;
    } exp_t;

    exp_t m;
    int   n_pass = 0;
    int   n_total = 0;
    bit   stall_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit [31:0] operand(input int a);
        if (a == 0) return 0;
        if (wb_en && int'(wb_addr) == a) return wb_data;
        return rf[a];
    endfunction

    function automatic bit uses_rs(input int op);
        return op == 0 || op == 8 || op == 35 || op == 43 || op == 4;
    endfunction

    function automatic bit uses_rt(input int op);
        return op == 0 || op == 43 || op == 4;
    endfunction

    function automatic exp_t model_decode();
        exp_t e;
        int op, rs, rt, rd;
        op = int'(id_instr[31:26]);
        rs = int'(id_instr[25:21]);
        rt = int'(id_instr[20:16]);
        rd = int'(id_instr[15:11]);
        e = '{default: 0};
        e.valid = id_valid;
        e.ra = operand(rs);
        e.rb = operand(rt);
        e.imm = 32'(signed'(id_instr[15:0]));
        e.pc = id_pc;
        e.funct = int'(id_instr[5:0]);
        if (op == 0) begin
            e.rw = rd != 0; e.dest = rd;
        end else if (op == 8) begin
            e.rw = 1; e.as = 1; e.dest = rt;
        end else if (op == 35) begin
            e.rw = 1; e.mr = 1; e.as = 1; e.dest = rt;
        end else if (op == 43) begin
            e.mw = 1; e.as = 1;
        end else if (op == 4) begin
            e.br = 1;
        end else begin
            e.ill = 1;
        end
        if (!id_valid) begin
            e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0;
        end
        return e;
    endfunction

    function automatic bit model_hazard();
        int op, rs, rt;
        op = int'(id_instr[31:26]);
        rs = int'(id_instr[25:21]);
        rt = int'(id_instr[20:16]);
        return m.valid && m.mr && m.dest != 0 && id_valid
            && ((m.dest == rs && uses_rs(op))
             || (m.dest == rt && uses_rt(op)));
    endfunction

    task automatic check_ex();
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        chk("ex_branch", 32'(ex_branch), 32'(m.br));
        if (m.valid) begin
            chk("ex_alu_src", 32'(ex_alu_src), 32'(m.as));
            chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
            chk("ex_ra_data", ex_ra_data, m.ra);
            chk("ex_rb_data", ex_rb_data, m.rb);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_dest", 32'(ex_dest), 32'(m.dest));
            chk("ex_funct", 32'(ex_funct), 32'(m.funct));
        end
    endtask

    task automatic cycle(input bit rn, input bit v, input logic [31:0] ins,
                         input bit we, input int wa, input logic [31:0] wd,
                         input bit fl, input bit st);
        exp_t nxt;
        bit hz;
        @(negedge clk);
        rstn = rn; id_valid = v; id_instr = ins;
        id_pc = $urandom; wb_en = we; wb_addr = 5'(wa); wb_data = wd;
        flush = fl; ex_stall = st;
        #1;
        hz = model_hazard();
        stall_seen = id_stall;
        chk("id_stall", 32'(id_stall), 32'((hz && !fl) || st));
        chk("rf_ra_addr", 32'(rf_ra_addr), 32'(ins[25:21]));
        chk("rf_rb_addr", 32'(rf_rb_addr), 32'(ins[20:16]));
        if (!rn) nxt = '{default: 0};
        else if (fl) nxt = '{default: 0};
        else if (st) nxt = m;
        else if (hz) nxt = '{default: 0};
        else nxt = model_decode();
        @(posedge clk);
        #1;
        if (we) rf[wa] = wd;
        m = nxt;
        check_ex();
    endtask

    function automatic logic [31:0] r_type(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_type(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    initial begin
        logic [31:0] ins;
        int op_pick, op;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        m = '{default: 0};
        rstn = 0; id_valid = 1; id_instr = i_type(8, 0, 1, 5);
        id_pc = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        flush = 0; ex_stall = 0;
        @(posedge clk);

        // reset held with ADDI r1,r0,5 in ID
        cycle(0, 1, i_type(8, 0, 1, 5), 0, 0, 0, 0, 0);
        cycle(0, 1, i_type(8, 0, 1, 5), 0, 0, 0, 0, 0);
        chk("rst_stall", 32'(stall_seen), 0);
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_ra", ex_ra_data, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_dest", 32'(ex_dest), 0);
        chk("rst_alu_src", 32'(ex_alu_src), 0);
        chk("rst_illegal", 32'(ex_illegal), 0);
        cycle(1, 1, i_type(8, 0, 1, 5), 0, 0, 0, 0, 0);
        chk("rel_valid", 32'(ex_valid), 1);
        chk("rel_dest", 32'(ex_dest), 1);
        chk("rel_imm", ex_imm, 5);
        chk("rel_alu_src", 32'(ex_alu_src), 1);

        // write-back bypass
        rf[3] = 32'h11; rf[4] = 32'h22;
        cycle(1, 1, r_type(3, 4, 5, 32), 1, 3, 32'hDEAD_BEEF, 0, 0);
        chk("byp_ra", ex_ra_data, 32'hDEAD_BEEF);
        chk("byp_rb", ex_rb_data, 32'h22);
        chk("byp_dest", 32'(ex_dest), 5);

        // r0 reads as zero even when written or bypassed
        rf[0] = 32'h55;
        cycle(1, 1, r_type(0, 4, 0, 32), 1, 0, 7, 0, 0);
        chk("r0_ra", ex_ra_data, 0);
        chk("r0_rw", 32'(ex_reg_write), 0);

        // load-use: LW r2,4(r1) then ADD r6,r2,r7
        cycle(1, 1, i_type(35, 1, 2, 4), 0, 0, 0, 0, 0);
        cycle(1, 1, r_type(2, 7, 6, 32), 0, 0, 0, 0, 0);
        chk("lu_stall", 32'(stall_seen), 1);
        chk("lu_bubble", 32'(ex_valid), 0);
        cycle(1, 1, r_type(2, 7, 6, 32), 1, 2, 32'h1234, 0, 0);
        chk("lu_nostall", 32'(stall_seen), 0);
        chk("lu_add_ra", ex_ra_data, 32'h1234);
        chk("lu_add_dest", 32'(ex_dest), 6);
        // SW r2,0(r8) stalls through rt
        cycle(1, 1, i_type(35, 1, 2, 4), 0, 0, 0, 0, 0);
        cycle(1, 1, i_type(43, 8, 2, 0), 0, 0, 0, 0, 0);
        chk("sw_stall", 32'(stall_seen), 1);
        cycle(1, 1, i_type(43, 8, 2, 0), 0, 0, 0, 0, 0);
        chk("sw_load", 32'(ex_mem_write), 1);
        // ADDI r9,r8,1 does not depend on r2
        cycle(1, 1, i_type(35, 1, 2, 4), 0, 0, 0, 0, 0);
        cycle(1, 1, i_type(8, 8, 9, 1), 0, 0, 0, 0, 0);
        chk("addi_nostall", 32'(stall_seen), 0);
        chk("addi_dest", 32'(ex_dest), 9);

        // EX stall holds ID/EX
        cycle(1, 1, i_type(8, 3, 10, 16'h8001), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, r_type(1, 2, 3, 0), 0, 0, 0, 0, 1);
            chk("hold_stall", 32'(stall_seen), 1);
            chk("hold_dest", 32'(ex_dest), 10);
            chk("hold_imm", ex_imm, 32'hFFFF_8001);
        end
        cycle(1, 1, r_type(1, 2, 3, 0), 0, 0, 0, 1, 1);
        chk("flush_stall_valid", 32'(ex_valid), 0);

        // flush during a load-use hazard
        cycle(1, 1, i_type(35, 1, 2, 4), 0, 0, 0, 0, 0);
        cycle(1, 1, r_type(2, 7, 6, 32), 0, 0, 0, 1, 0);
        chk("flush_hz_stall", 32'(stall_seen), 0);
        chk("flush_hz_valid", 32'(ex_valid), 0);

        // illegal opcode
        cycle(1, 1, {6'h3F, 26'h123_4567}, 0, 0, 0, 0, 0);
        chk("ill_valid", 32'(ex_valid), 1);
        chk("ill_flag", 32'(ex_illegal), 1);
        chk("ill_ctl", {28'd0, ex_reg_write, ex_mem_read,
                        ex_mem_write, ex_branch}, 0);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            op_pick = $urandom_range(0, 6);
            case (op_pick)
                0: op = 0;
                1: op = 8;
                2, 3: op = 35;
                4: op = 43;
                5: op = 4;
                default: op = $urandom_range(0, 63);
            endcase
            ins = $urandom;
            ins[31:26] = 6'(op);
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = 5'($urandom_range(0, 3));
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0, ins,
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
